// File: rtl/pio_gen2_pkg.sv
// Shared constants for the generation-2 Avalon PIO: register word offsets and edge-mode codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pio_gen2_pkg;

  // Register map, word offsets on avs_address
  localparam logic [2:0] OFF_DATA_IN  = 3'd0;
  localparam logic [2:0] OFF_DATA_OUT = 3'd1;
  localparam logic [2:0] OFF_IRQ_MASK = 3'd2;
  localparam logic [2:0] OFF_EDGE_CAP = 3'd3;
  localparam logic [2:0] OFF_OUT_SET  = 3'd4;
  localparam logic [2:0] OFF_OUT_CLR  = 3'd5;

  // Which debounced transition sets an edge-capture bit
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce.sv
// One input bit: 2-FF synchroniser followed by a stable-count debouncer.
// Latency: pin to db is 2 + DEBOUNCE_CYCLES clocks (3 when DEBOUNCE_CYCLES = 0).
// Backpressure: none; free-running every clock.
// Ports: clk, reset_n (async active-low), pin (asynchronous input), db (debounced level).
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic db
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) db <= 1'b0;
        else          db <= sync2;
      end
    end else begin : g_count
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt;

      // Counter restarts whenever the synchronised input agrees with db again,
      // so any excursion shorter than DEBOUNCE_CYCLES is discarded and the
      // counter can never pass CNT_LAST.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
          db  <= 1'b0;
        end else if (sync2 == db) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt <= '0;
          db  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/avalon_pio_gen2.sv
// Avalon-MM PIO: output bank with atomic set/clear, debounced input bank, edge capture, maskable level irq.
// Latency: writes land on the sampling edge; avs_readdata is registered, valid one clock after avs_read.
// Backpressure: none (no waitrequest); every access completes in a single cycle.
// Ports: clk/reset_n; avs_address/read/write/writedata/readdata slave; in_port (async), out_port, irq.
module avalon_pio_gen2
  import pio_gen2_pkg::*;
#(
  parameter int          IN_W            = 10,
  parameter int          OUT_W           = 10,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_MODE       = 0,
  parameter logic [31:0] OUT_RESET       = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [IN_W-1:0]  in_port,
  output logic [OUT_W-1:0] out_port,
  output logic             irq
);

  logic [IN_W-1:0]  db;
  logic [IN_W-1:0]  db_prev;
  logic [IN_W-1:0]  edge_evt;
  logic [IN_W-1:0]  edge_cap;
  logic [IN_W-1:0]  edge_clr;
  logic [IN_W-1:0]  irq_mask;
  logic [OUT_W-1:0] out_reg;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Writedata bits above IN_W/OUT_W are deliberately dropped.
  assign unused_wdata = ^avs_writedata;

  generate
    for (genvar i = 0; i < IN_W; i++) begin : g_in
      pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (in_port[i]),
        .db      (db[i])
      );
    end
  endgenerate

  always_comb begin
    edge_evt = db ^ db_prev;
    if (EDGE_MODE == EDGE_RISE)      edge_evt = db & ~db_prev;
    else if (EDGE_MODE == EDGE_FALL) edge_evt = ~db & db_prev;
  end

  assign edge_clr = (avs_write && avs_address == OFF_EDGE_CAP) ? avs_writedata[IN_W-1:0] : '0;

  always_comb begin
    rd_mux = 32'h0;
    case (avs_address)
      OFF_DATA_IN:  rd_mux = 32'(db);
      OFF_DATA_OUT: rd_mux = 32'(out_reg);
      OFF_IRQ_MASK: rd_mux = 32'(irq_mask);
      OFF_EDGE_CAP: rd_mux = 32'(edge_cap);
      default:      rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev      <= '0;
      edge_cap     <= '0;
      irq_mask     <= '0;
      out_reg      <= OUT_RESET[OUT_W-1:0];
      avs_readdata <= 32'h0;
    end else begin
      db_prev <= db;
      // Clear applied first so a coincident new event keeps the bit set.
      edge_cap <= (edge_cap & ~edge_clr) | edge_evt;
      // Read mux samples pre-write state, so read+write returns the old value.
      if (avs_read) avs_readdata <= rd_mux;
      if (avs_write) begin
        case (avs_address)
          OFF_DATA_OUT: out_reg  <= avs_writedata[OUT_W-1:0];
          OFF_IRQ_MASK: irq_mask <= avs_writedata[IN_W-1:0];
          OFF_OUT_SET:  out_reg  <= out_reg | avs_writedata[OUT_W-1:0];
          OFF_OUT_CLR:  out_reg  <= out_reg & ~avs_writedata[OUT_W-1:0];
          default:      ;
        endcase
      end
    end
  end

  assign out_port = out_reg;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_avalon_pio_gen2.sv
// Directed bench for avalon_pio_gen2: rising-edge instance plus an any-edge instance on the same bus.
// Latency: stimulus changes just after a rising edge; outputs sampled 1 time unit after the edge.
// Backpressure: n/a.
module tb_avalon_pio_gen2;
  import pio_gen2_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [9:0]  in_port = '0;
  logic [9:0]  out1;
  logic [9:0]  out2;
  logic        irq1;
  logic        irq2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  avalon_pio_gen2 #(.IN_W(10), .OUT_W(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .OUT_RESET(32'h155)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd1),
    .in_port(in_port), .out_port(out1), .irq(irq1)
  );

  avalon_pio_gen2 #(.IN_W(10), .OUT_W(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .OUT_RESET(32'h155)) dut_any (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd2),
    .in_port(in_port), .out_port(out2), .irq(irq2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end at posedge+1.
  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_address = addr; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    data = rd1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] d;

  initial begin
    // Reset state
    idle(3);
    check_val("rst_out_port", 32'(out1), 32'h155);
    check_val("rst_irq", 32'(irq1), 32'h0);
    check_val("rst_readdata", rd1, 32'h0);
    reset_n = 1'b1;
    idle(2);
    bus_read(OFF_DATA_IN, d);  check_val("rst_data_in", d, 32'h0);
    bus_read(OFF_IRQ_MASK, d); check_val("rst_irq_mask", d, 32'h0);
    bus_read(OFF_EDGE_CAP, d); check_val("rst_edge_cap", d, 32'h0);
    bus_read(OFF_DATA_OUT, d); check_val("rst_data_out", d, 32'h155);

    // Debounce latency on bit 3: db valid after edge 6, visible to a read sampled at edge 7
    bus_write(OFF_IRQ_MASK, 32'h008);
    in_port[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      bus_read(OFF_DATA_IN, d);
      check_val($sformatf("din_latency_k%0d", k), d, (k >= 7) ? 32'h008 : 32'h0);
    end
    check_val("irq_after_rise", 32'(irq1), 32'h1);
    bus_read(OFF_EDGE_CAP, d);
    check_val("edge_cap_rise", d, 32'h008);
    check_val("edge_cap_rise_any", rd2, 32'h008);
    idle(2);
    check_val("readdata_hold", rd1, 32'h008);

    // 3-cycle glitch on bit 2 is filtered
    in_port[2] = 1'b1;
    idle(3);
    in_port[2] = 1'b0;
    idle(10);
    bus_read(OFF_DATA_IN, d);  check_val("glitch_data_in", d, 32'h008);
    bus_read(OFF_EDGE_CAP, d); check_val("glitch_edge_cap", d, 32'h008);

    // W1C drops irq on the next cycle
    bus_write(OFF_EDGE_CAP, 32'h008);
    check_val("w1c_irq", 32'(irq1), 32'h0);
    bus_read(OFF_EDGE_CAP, d);
    check_val("w1c_edge_cap", d, 32'h0);
    check_val("w1c_edge_cap_any", rd2, 32'h0);

    // Falling edge: ignored in rising mode, captured in any-edge mode
    in_port[3] = 1'b0;
    idle(10);
    bus_read(OFF_EDGE_CAP, d);
    check_val("fall_edge_cap_rise_mode", d, 32'h0);
    check_val("fall_edge_cap_any_mode", rd2, 32'h008);
    bus_read(OFF_DATA_IN, d);
    check_val("fall_data_in", d, 32'h0);
    bus_write(OFF_EDGE_CAP, 32'h008);

    // Masking a pending bit drops irq but keeps edge_cap
    in_port[3] = 1'b1;
    idle(10);
    check_val("pending_irq", 32'(irq1), 32'h1);
    bus_write(OFF_IRQ_MASK, 32'h0);
    check_val("masked_irq", 32'(irq1), 32'h0);
    bus_read(OFF_EDGE_CAP, d);
    check_val("masked_edge_cap", d, 32'h008);
    bus_write(OFF_IRQ_MASK, 32'h008);
    check_val("unmasked_irq", 32'(irq1), 32'h1);

    // Set wins over a coincident W1C
    in_port[3] = 1'b0;
    idle(10);
    bus_write(OFF_EDGE_CAP, 32'h008);
    bus_read(OFF_EDGE_CAP, d);
    check_val("pre_setwin_edge_cap", d, 32'h0);
    in_port[3] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus_write(OFF_EDGE_CAP, 32'h008);   // sampled on the same edge that sets the bit
    bus_read(OFF_EDGE_CAP, d);
    check_val("set_wins_edge_cap", d, 32'h008);
    bus_write(OFF_EDGE_CAP, 32'h008);
    bus_read(OFF_EDGE_CAP, d);
    check_val("later_w1c_edge_cap", d, 32'h0);

    // Output bank: write, set, clear
    bus_write(OFF_DATA_OUT, 32'h0F0); check_val("out_write", 32'(out1), 32'h0F0);
    bus_write(OFF_OUT_SET, 32'h003);  check_val("out_set", 32'(out1), 32'h0F3);
    bus_write(OFF_OUT_CLR, 32'h030);  check_val("out_clr", 32'(out1), 32'h0C3);
    bus_read(OFF_DATA_OUT, d); check_val("data_out_read", d, 32'h0C3);
    bus_read(OFF_OUT_SET, d);  check_val("out_set_reads0", d, 32'h0);
    bus_read(OFF_OUT_CLR, d);  check_val("out_clr_reads0", d, 32'h0);
    bus_read(3'd6, d);         check_val("reserved_reads0", d, 32'h0);
    bus_write(OFF_DATA_IN, 32'h3FF);
    bus_read(OFF_DATA_IN, d);  check_val("data_in_readonly", d, 32'h008);
    bus_write(OFF_DATA_OUT, 32'hFFFF_F3FF);
    check_val("out_upper_ignored", 32'(out1), 32'h3FF);

    // Read and write in the same cycle return the pre-write value
    @(negedge clk);
    avs_address = OFF_DATA_OUT; avs_writedata = 32'h001; avs_write = 1'b1; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0; avs_read = 1'b0;
    check_val("rw_same_cycle_read", rd1, 32'h3FF);
    check_val("rw_same_cycle_out", 32'(out1), 32'h001);
    bus_write(OFF_DATA_OUT, 32'h3FF);

    // Mid-debounce reset on bit 5
    in_port[5] = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_val("midrst_out_port", 32'(out1), 32'h155);
    check_val("midrst_irq", 32'(irq1), 32'h0);
    check_val("midrst_readdata", rd1, 32'h0);
    idle(3);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      bus_read(OFF_DATA_IN, d);
      check_val($sformatf("postrst_din_k%0d", k), d, (k >= 7) ? 32'h028 : 32'h0);
    end
    bus_read(OFF_EDGE_CAP, d); check_val("postrst_edge_cap", d, 32'h028);
    bus_read(OFF_IRQ_MASK, d); check_val("postrst_irq_mask", d, 32'h0);
    check_val("postrst_irq", 32'(irq1), 32'h0);
    bus_read(OFF_DATA_OUT, d); check_val("postrst_data_out", d, 32'h155);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
